joy_conditioner: RTL
====================

Name: joy_conditioner

Overview:
Conditions the raw joystick bits from the MCP23S17 SPI expander poller before they reach the Minimig core's JOYA/JOYB inputs. Per port it provides:
- 2-flop input registering
- per-bit debounce
- opposite-direction (SOCD) cleanup
- optional autofire on the primary fire button
- a one-cycle change strobe

It sits between the expander poller and the core. It runs on clk_28.

Parameters:
DEBOUNCE_CYCLES, 28000, consecutive cycles an input must differ from its debounced value before the debounced value updates (1 ms at 28 MHz); legal range 2..2^CNT_W-1
AUTOFIRE_HALF, 1400000, autofire half-period in clk cycles (50 ms, 10 Hz)
CNT_W, 21, width of debounce and autofire counters; must hold max(DEBOUNCE_CYCLES, AUTOFIRE_HALF)

Ports:
clk  input  1  system clock (clk_28 domain)
rst  input  1  asynchronous reset, active-high
autofire_a  input  1  1 = autofire enabled on port A fire (bit 4)
autofire_b  input  1  1 = autofire enabled on port B fire (bit 4)
joya_in  input  6  raw port A, active-low: 5 fire2, 4 fire, 3 up, 2 down, 1 left, 0 right
joyb_in  input  6  raw port B, same mapping
joya_out  output  7  conditioned port A, active-low; bit 6 constant 1
joyb_out  output  7  conditioned port B, same
changed  output  1  one-cycle pulse when joya_out or joyb_out changed value

Behaviour:
- Reset (async assert, sync release by caller):
  - sync flops, debounced state and outputs = all ones (7'h7F on outputs)
  - all counters = 0; autofire phase = pressed; changed = 0
- Input stage: two flops per bit, reset to 1. The second flop is s2.
- Debounce, per bit (12 independent instances):
  - Register stable and counter cnt.
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any return to agreement restarts the count from 0.
- SOCD, combinational on the debounced value:
  - up and down both pressed (bits 3 and 2 both 0) -> both reported released (1).
  - left and right both pressed (bits 1 and 0 both 0) -> both reported released (1).
  - Fire bits are unaffected.
- Autofire, per port (af counter, phase bit):
  - Fire not pressed (debounced bit 4 = 1) or autofire_x = 0: af <= 0, phase <= pressed, fire output follows debounced bit 4.
  - Fire pressed and autofire_x = 1:
    - fire output = phase;
    - when af == AUTOFIRE_HALF-1, phase toggles and af <= 0; otherwise af increments.
    - The first pressed interval is AUTOFIRE_HALF cycles, starting when the debounced press appears.
  - autofire_x deasserted mid-burst: next output follows debounced fire (pressed).
  - Fire released mid-burst: output released on the next cycle and the phase is rearmed.
  - autofire_x is sampled directly and needs no sync; the caller drives it from the clk domain.
- Outputs:
  - joyX_out registered; bit 6 tied to 1.
  - changed <= (new joya_out != current joya_out) | (new joyb_out != current joyb_out), registered alongside the outputs.
- Latency: an input edge held steady reaches joyX_out exactly DEBOUNCE_CYCLES+3 rising edges after the edge is presented. This comprises 2 sync edges, DEBOUNCE_CYCLES debounce edges and 1 output-register edge.
- Simultaneous edges on several bits debounce independently. changed pulses once per cycle in which any output bit moves, not once per bit.
- Reset mid-count discards partial counts. Post-reset, a held-pressed input needs a full debounce interval before it is reported.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=16, AUTOFIRE_HALF=40.)
1. Glitch rejection: joya_in[4] low for 15 cycles, then high -> joya_out stays 7'h7F; changed never pulses.
2. Clean press: joya_in[4] low and held -> joya_out = 7'h6F exactly 19 edges after the input edge; changed high for exactly 1 cycle. Release -> 7'h7F after 19 edges and a second single pulse.
3. Bounce: joyb_in[0] toggling every 5 cycles for 50 cycles, then held low -> exactly one transition to joyb_out = 7'h7E and exactly one changed pulse.
4. SOCD: joya_in[3] and joya_in[2] both held low -> joya_out stays 7'h7F. Release bit 2 -> joya_out = 7'h77 19 edges later.
5. Autofire: autofire_a = 1, joya_in[4] held low for 300 cycles -> bit 4 goes 0 for 40 cycles, 1 for 40, 0 for 40, and so on, with changed pulsing at each toggle. Release -> bit 4 = 1 and stays 1. Clearing autofire_a mid-burst -> bit 4 = 0 and steady.
6. Async reset: assert rst at the 10th debounce count while outputs are mid-change -> joya_out/joyb_out = 7'h7F immediately and changed = 0. After release with input still low -> output changes only after a fresh 19-edge interval.

Source files
------------

// File: rtl/joy_conditioner.sv
// joy_conditioner: sync, debounce, SOCD cleanup and autofire for two joystick ports
module joy_conditioner #(
  parameter int DEBOUNCE_CYCLES = 28000,
  parameter int AUTOFIRE_HALF   = 1400000,
  parameter int CNT_W           = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       autofire_a,
  input  logic       autofire_b,
  input  logic [5:0] joya_in,
  input  logic [5:0] joyb_in,
  output logic [6:0] joya_out,
  output logic [6:0] joyb_out,
  output logic       changed
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AF_LAST = CNT_W'(AUTOFIRE_HALF - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  logic [11:0]      s1, s2, stable;
  logic [CNT_W-1:0] cnt [12];
  logic [CNT_W-1:0] af [2];
  logic [1:0]       phase, af_on;
  logic [6:0]       na, nb;

  // bits 3/2 and 1/0 pressed together cancel; fire comes from the autofire phase while it runs
  function automatic logic [6:0] shape(input logic [5:0] v, input logic on, input logic ph);
    logic ud, lr;
    ud = ~(v[3] | v[2]);
    lr = ~(v[1] | v[0]);
    return {1'b1, v[5], on ? ph : v[4], v[3] | ud, v[2] | ud, v[1] | lr, v[0] | lr};
  endfunction

  assign af_on = {autofire_b & ~stable[10], autofire_a & ~stable[4]};

  // two-flop input registering, port B in the upper six bits
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= {joyb_in, joya_in};
      s2 <= s1;
    end

  // per-bit debounce: commit only after DEBOUNCE_CYCLES consecutive disagreements
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stable <= '1;
      for (int i = 0; i < 12; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 12; i++)
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == DB_LAST) begin
          stable[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + ONE;
    end

  // autofire half-period timer and phase per port, rearmed to pressed whenever idle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase <= '0;
      for (int p = 0; p < 2; p++) af[p] <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (!af_on[p]) begin
          af[p] <= '0;
          phase[p] <= 1'b0;
        end else if (af[p] == AF_LAST) begin
          af[p] <= '0;
          phase[p] <= ~phase[p];
        end else af[p] <= af[p] + ONE;
    end

  // next output values
  always_comb begin
    na = shape(stable[5:0], af_on[0], phase[0]);
    nb = shape(stable[11:6], af_on[1], phase[1]);
  end

  // registered outputs and change strobe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      joya_out <= 7'h7F;
      joyb_out <= 7'h7F;
      changed  <= 1'b0;
    end else begin
      joya_out <= na;
      joyb_out <= nb;
      changed  <= (na != joya_out) | (nb != joyb_out);
    end
endmodule
